// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving a shared RV32I-subset datapath, with retired-instruction count.
// Latency: lw 5, sw/R/I 4, branch/jal 3 cycles with zero-wait memory; strobes decode combinationally from state.
// Backpressure: FETCH and MEM hold with mem_req/mem_we/iord stable until mem_ready; mem_ready is ignored elsewhere.
module multicycle_ctrl #(
    parameter int RESET_PC_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        alu_zero,
    input  logic        alu_lt,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pcsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  aluop,
    output logic        regwrite,
    output logic [1:0]  memtoreg,
    output logic [31:0] imm,
    output logic        illegal,
    output logic [31:0] instret
);

    // State encoding
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    // Opcodes of the supported subset
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Datapath mux codes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_STEP  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_CMP    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;

    // A zero PC step leaves PC unchanged in FETCH, so its write is skipped
    localparam logic PC_ADVANCES = (RESET_PC_STEP != 0);

    logic [2:0]  r_state;
    logic        r_run;
    logic [31:0] r_instret;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_ialu;
    logic        w_is_ralu;
    logic        w_is_br;
    logic        w_is_jal;
    logic        w_br_ok;
    logic        w_legal;
    logic        w_taken;
    logic        w_out_en;

    logic [2:0]  w_next;
    logic        w_retire;
    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_iord;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_pcsrc;
    logic [1:0]  w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [1:0]  w_aluop;
    logic        w_regwrite;
    logic [1:0]  w_memtoreg;
    logic        w_illegal;

    assign w_opcode  = inst[6:0];
    assign w_funct3  = inst[14:12];
    assign w_is_lw   = (w_opcode == OP_LOAD);
    assign w_is_sw   = (w_opcode == OP_STORE);
    assign w_is_ialu = (w_opcode == OP_IALU);
    assign w_is_ralu = (w_opcode == OP_RALU);
    assign w_is_br   = (w_opcode == OP_BRANCH);
    assign w_is_jal  = (w_opcode == OP_JAL);

    // Only beq/bne/blt/bge are implemented among the branch funct3 codes
    assign w_br_ok = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) ||
                     (w_funct3 == 3'b100) || (w_funct3 == 3'b101);

    assign w_legal = w_is_lw || w_is_sw || w_is_ialu || w_is_ralu ||
                     w_is_jal || (w_is_br && w_br_ok);

    // Branch condition from the ALU compare flags
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = alu_zero;
            3'b001:  w_taken = !alu_zero;
            3'b100:  w_taken = alu_lt;
            3'b101:  w_taken = !alu_lt;
            default: w_taken = 1'b0;
        endcase
    end

    // Immediate generation by opcode format; stays live through reset
    always_comb begin
        imm = 32'd0;
        if (w_is_lw || w_is_ialu) begin
            imm = {{20{inst[31]}}, inst[31:20]};
        end else if (w_is_sw) begin
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        end else if (w_is_br) begin
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        end else if (w_is_jal) begin
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        end
    end

    // Next-state and per-state datapath strobes
    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_iord     = 1'b0;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_pcsrc    = 1'b0;
        w_alusrca  = SRCA_PC;
        w_alusrcb  = SRCB_RS2;
        w_aluop    = ALU_ADD;
        w_regwrite = 1'b0;
        w_memtoreg = WB_ALUOUT;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b0;
                if (mem_ready) begin
                    // PC <= PC + step while IR/old-PC capture the fetched word
                    w_ir_write = 1'b1;
                    w_pc_write = PC_ADVANCES;
                    w_pcsrc    = 1'b0;
                    w_alusrca  = SRCA_PC;
                    w_alusrcb  = SRCB_STEP;
                    w_aluop    = ALU_ADD;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut <= old-PC + imm, the branch/jump target
                w_alusrca = SRCA_OLDPC;
                w_alusrcb = SRCB_IMM;
                w_aluop   = ALU_ADD;
                w_next    = w_legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (w_is_lw || w_is_sw) begin
                    w_alusrca = SRCA_RS1;
                    w_alusrcb = SRCB_IMM;
                    w_aluop   = ALU_ADD;
                    w_next    = S_MEM;
                end else if (w_is_ialu) begin
                    w_alusrca = SRCA_RS1;
                    w_alusrcb = SRCB_IMM;
                    w_aluop   = ALU_FUNCT;
                    w_next    = S_WB;
                end else if (w_is_ralu) begin
                    w_alusrca = SRCA_RS1;
                    w_alusrcb = SRCB_RS2;
                    w_aluop   = ALU_FUNCT;
                    w_next    = S_WB;
                end else if (w_is_br && w_br_ok) begin
                    w_alusrca  = SRCA_RS1;
                    w_alusrcb  = SRCB_RS2;
                    w_aluop    = ALU_CMP;
                    w_pc_write = w_taken;
                    w_pcsrc    = 1'b1;
                    w_next     = S_FETCH;
                    w_retire   = 1'b1;
                end else if (w_is_jal) begin
                    // PC already holds old-PC + step, which is the link value
                    w_pc_write = 1'b1;
                    w_pcsrc    = 1'b1;
                    w_regwrite = 1'b1;
                    w_memtoreg = WB_PC;
                    w_next     = S_FETCH;
                    w_retire   = 1'b1;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = w_is_sw;
                if (mem_ready) begin
                    if (w_is_sw) begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end else if (w_is_lw) begin
                        w_next = S_WB;
                    end else begin
                        w_next = S_TRAP;
                    end
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_memtoreg = w_is_lw ? WB_MDR : WB_ALUOUT;
                w_next     = S_FETCH;
                w_retire   = 1'b1;
            end
            S_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_next = S_TRAP;
            end
        endcase
    end

    // Outputs stay quiet while reset is asserted and until it has been sampled released
    assign w_out_en = rst_n && r_run;

    assign mem_req  = w_out_en && w_mem_req;
    assign mem_we   = w_out_en && w_mem_we;
    assign iord     = w_out_en && w_iord;
    assign ir_write = w_out_en && w_ir_write;
    assign pc_write = w_out_en && w_pc_write;
    assign pcsrc    = w_out_en && w_pcsrc;
    assign alusrca  = w_out_en ? w_alusrca  : 2'b00;
    assign alusrcb  = w_out_en ? w_alusrcb  : 2'b00;
    assign aluop    = w_out_en ? w_aluop    : 2'b00;
    assign regwrite = w_out_en && w_regwrite;
    assign memtoreg = w_out_en ? w_memtoreg : 2'b00;
    assign illegal  = w_out_en && w_illegal;
    assign instret  = rst_n ? r_instret : 32'd0;

    // State, run flag and retired-instruction counter with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_instret <= 32'd0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state <= w_next;
                if (w_retire) begin
                    r_instret <= r_instret + 32'd1;
                end
            end
        end
    end

endmodule
